// File: rtl/dm_pipe.sv
// dm_pipe: word-addressed data memory with a fixed-latency response pipeline.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_width, req_sign, req_pc
//   resp_valid, resp_rdata, resp_exc, resp_code
module dm_pipe #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          RD_LAT      = 1,
    parameter bit          LOG_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [1:0]  resp_code
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [RD_LAT-1:0]       pv_q, pv_d;
    logic [RD_LAT-1:0][31:0] pd_q, pd_d;
    logic [RD_LAT-1:0]       pe_q, pe_d;
    logic [RD_LAT-1:0][1:0]  pc_q, pc_d;

    logic [31:0]   rel;
    logic [1:0]    offset;
    logic [AW-1:0] idx;
    logic          oor;
    logic          accept;
    logic [1:0]    code;
    logic          fault;
    logic [31:0]   old_word;
    logic [3:0]    be;
    logic [31:0]   wr_data;
    logic [31:0]   merged;
    logic [15:0]   ld_half;
    logic [7:0]    ld_byte;
    logic [31:0]   ld_data;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    assign req_ready = (state_q == RUN);

    always_comb begin
        rel    = req_addr - BASE_ADDR;
        offset = rel[1:0];
        idx    = rel[AW+1:2];
        oor    = |rel[31:AW+2];
        accept = reset & req_valid & req_ready;

        // Bad width beats misalignment, which beats range.
        code = 2'd0;
        if (req_width == 2'd3)
            code = 2'd3;
        else if ((req_width == 2'd0 && offset != 2'd0) ||
                 (req_width == 2'd1 && offset[0]))
            code = 2'd1;
        else if (oor)
            code = 2'd2;
        fault = (code != 2'd0);

        // Memory is read before the accepting edge, so a load sees
        // every store accepted on earlier edges and none after.
        old_word = mem_q[idx];

        be      = 4'b0000;
        wr_data = req_wdata;
        unique case (req_width)
            2'd0: be = 4'b1111;
            2'd1: begin
                be      = offset[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                be      = 4'b0001 << offset;
                wr_data = {4{req_wdata[7:0]}};
            end
            default: be = 4'b0000;
        endcase

        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? wr_data[8*i +: 8] : old_word[8*i +: 8];

        ld_half = offset[1] ? old_word[31:16] : old_word[15:0];
        unique case (offset)
            2'd0: ld_byte = old_word[7:0];
            2'd1: ld_byte = old_word[15:8];
            2'd2: ld_byte = old_word[23:16];
            default: ld_byte = old_word[31:24];
        endcase

        ld_data = 32'h0;
        unique case (req_width)
            2'd0: ld_data = old_word;
            2'd1: ld_data = {{16{req_sign & ld_half[15]}}, ld_half};
            2'd2: ld_data = {{24{req_sign & ld_byte[7]}}, ld_byte};
            default: ld_data = 32'h0;
        endcase
        if (req_we || fault)
            ld_data = 32'h0;
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_widx  = clr_cnt_q;
        mem_wdata = 32'h0;
        unique case (state_q)
            CLEAR: begin
                mem_we    = reset;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH_WORDS - 1))
                    state_d = RUN;
            end
            RUN: begin
                if (accept && req_we && !fault) begin
                    mem_we    = 1'b1;
                    mem_widx  = idx;
                    mem_wdata = merged;
                end
            end
        endcase
    end

    always_comb begin
        pv_d    = pv_q;
        pd_d    = pd_q;
        pe_d    = pe_q;
        pc_d    = pc_q;
        pv_d[0] = accept;
        pd_d[0] = accept ? ld_data : 32'h0;
        pe_d[0] = accept & fault;
        pc_d[0] = accept ? code : 2'd0;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
            pe_d[i] = pe_q[i-1];
            pc_d[i] = pc_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            pv_q      <= '0;
            pd_q      <= '0;
            pe_q      <= '0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pv_q      <= pv_d;
            pd_q      <= pd_d;
            pe_q      <= pe_d;
            pc_q      <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_widx] <= mem_wdata;
    end

    assign resp_valid = pv_q[RD_LAT-1];
    assign resp_rdata = pd_q[RD_LAT-1];
    assign resp_exc   = pe_q[RD_LAT-1];
    assign resp_code  = pc_q[RD_LAT-1];

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (LOG_EN && state_q == RUN && mem_we)
            $display("%d@%h: *%h <= %h", $time, req_pc,
                     {req_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 4096, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (word-aligned).
REQ-003 SHALL provide parameter RD_LAT, default 1, response latency in cycles after acceptance (legal 1..4).
REQ-004 SHALL provide parameter LOG_EN, default 1, enables the simulation write log.
REQ-005 SHALL provide ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_width  in  2  0 word, 1 half, 2 byte, 3 reserved.
- req_sign  in  1  sign-extend half/byte loads.
- req_pc  in  32  PC of issuing instruction, log only.
- resp_valid  out  1  response present, one cycle per accepted request.
- resp_rdata  out  32  load data, extended; 0 for stores and exceptions.
- resp_exc  out  1  request faulted.
- resp_code  out  2  0 none, 1 misaligned, 2 out of range, 3 bad width.

Function
REQ-006 SHALL implement FSM {CLEAR, RUN}; reset low forces CLEAR with clear counter = 0.
REQ-007 In CLEAR SHALL zero one word per cycle at index = counter, increment counter, and go to RUN on the cycle it zeroes word DEPTH_WORDS-1.
REQ-008 req_ready SHALL be 0 in CLEAR and 1 in RUN; no backpressure from the response side.
REQ-009 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; one request per cycle, back-to-back allowed.
REQ-010 Word index SHALL be (req_addr - BASE_ADDR) >> 2; offset = req_addr[1:0].
REQ-011 Fault priority SHALL be: width 3 -> code 3; else word with offset != 0 or half with offset[0] = 1 -> code 1; else (req_addr - BASE_ADDR) unsigned >= 4*DEPTH_WORDS -> code 2.
REQ-012 A faulting store SHALL not modify memory; a faulting load SHALL return resp_rdata = 0.
REQ-013 Non-faulting store SHALL commit at the accepting edge: word writes all 4 bytes; half writes bytes [offset+1:offset]; byte writes lane offset; other lanes unchanged.
REQ-014 Non-faulting load SHALL sample memory at the accepting edge: half selects [31:16] if offset[1] else [15:0]; byte selects lane offset; zero- or sign-extend per req_sign; word ignores req_sign.
REQ-015 A load accepted the cycle after a store to the same word SHALL return the post-store value; stores accepted after a load SHALL not alter that load's response.
REQ-016 resp_valid/resp_rdata/resp_exc/resp_code SHALL appear exactly RD_LAT cycles after acceptance, in acceptance order, via an RD_LAT-deep shift pipeline.
REQ-017 Stores SHALL also produce a response (resp_rdata = 0, exc per REQ-011).
REQ-018 With LOG_EN=1, each committed store SHALL print "%d@%h: *%h <= %h" with $time, req_pc, word-aligned byte address, and the full merged word after the write; faulting stores print nothing.

Reset
REQ-019 While reset=0 at an edge: resp_valid=0, resp_rdata=0, resp_exc=0, resp_code=0, all pipeline stages invalidated, state=CLEAR, counter=0.
REQ-020 Reset low mid-CLEAR or mid-RUN SHALL discard in-flight responses and restart clearing from word 0; no response for a request accepted in the reset cycle.
REQ-021 After reset release, req_ready SHALL rise exactly DEPTH_WORDS cycles later; all words read 0.

Verification
REQ-022 DEPTH_WORDS=16, RD_LAT=1: release reset -> req_ready=0 for 16 cycles, then 1; load word 0x0 -> resp_rdata=0 one cycle later.
REQ-023 Store word 0x4=0x8765_4321, store byte 0x5=0xAA, load half 0x4 sign=1 -> resp_rdata=0xFFFF_AA21; sign=0 -> 0x0000_AA21; log shows *00000004 <= 8765aa21.
REQ-024 RD_LAT=3, back-to-back load 0x0, store 0x0=0x1, load 0x0 -> three responses on cycles +3,+4,+5 with rdata 0, 0, 0x1.
REQ-025 Load word 0x2 -> exc=1 code=1; store half 0x3 -> code 1, memory unchanged; width 3 at 0x1 -> code 3; load at BASE_ADDR+64 (DEPTH 16) -> code 2, rdata 0.
REQ-026 Assert reset low with 2 loads in flight -> no resp_valid afterwards, req_ready=0, previously stored word reads 0 after clear completes.
